vector_sequencer: RTL
=====================

Name: vector_sequencer

Overview:
- Sequences a combinational datapath under test (15-bit in, 30-bit out) through a stored stimulus list, one vector at a time.
- For each vector: fetches the stimulus, holds it for a programmable settle time, captures the result, and writes it to a result memory.
- Compares each result against a golden value and keeps mismatch statistics.
- Sits between the stimulus/expected memories and the datapath. It replaces the one-shot "apply, wait #1, dump" flow with a clocked, multi-vector run.

Parameters:
- DIN_W, 15, stimulus / datapath input width
- DOUT_W, 30, datapath output / result width
- ADDR_W, 4, vector address width; up to 2**ADDR_W vectors per run
- SETTLE, 1, cycles the stimulus is held before capture (>=1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  run request, sampled only in IDLE
- num_vec  in  ADDR_W+1  vectors in this run, latched at start; 0..2**ADDR_W
- vec_addr  out  ADDR_W  stimulus/expected memory read address
- vec_data  in  DIN_W  stimulus word at vec_addr (combinational read)
- exp_data  in  DOUT_W  golden result at vec_addr (combinational read)
- cmp_mask  in  DOUT_W  1 = bit is compared; latched at start
- dut_in  out  DIN_W  registered drive to datapath input
- dut_out  in  DOUT_W  datapath output
- res_we  out  1  result-memory write strobe
- res_addr  out  ADDR_W  result write address
- res_data  out  DOUT_W  captured dut_out
- busy  out  1  high from LOAD through CAPTURE
- done  out  1  one-cycle pulse at end of run
- mismatch_cnt  out  ADDR_W+1  failing vectors this run, saturating
- fail_valid  out  1  at least one mismatch this run
- first_fail  out  ADDR_W  address of first failing vector

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0, including dut_in, vec_addr, counters and first_fail. Reset mid-run aborts with no done pulse; the partial result memory is not cleared.
- FSM states: IDLE, LOAD, SETTLE, CAPTURE, DONE.
- IDLE:
  - start=1 and num_vec!=0: latch num_vec and cmp_mask; clear mismatch_cnt, fail_valid, first_fail; vec_addr=0; go to LOAD.
  - start=1 and num_vec=0: clear stats; go to DONE.
  - start while not IDLE is ignored; no queuing.
- LOAD (1 cycle): dut_in <= vec_data on exit; settle counter <= SETTLE-1; go to SETTLE.
- SETTLE: stays while counter!=0, decrementing each cycle, so the state lasts exactly SETTLE cycles; then CAPTURE. dut_in stays stable.
- CAPTURE (1 cycle):
  - res_we=1, res_addr=vec_addr, res_data=dut_out, all combinational in this state.
  - Mismatch = ((dut_out ^ exp_data) & cmp_mask) != 0.
  - On mismatch: mismatch_cnt+1, saturating at all-ones. If fail_valid=0, set fail_valid=1 and first_fail=vec_addr.
  - If vec_addr==num_vec-1, go to DONE; otherwise vec_addr+1 and go to LOAD.
  - For num_vec=2**ADDR_W the last address is all-ones; vec_addr never wraps within a run.
- DONE (1 cycle): done=1, busy=0; go to IDLE. Stats and dut_in hold until the next start or reset.
- Timing:
  - Per-vector cost = SETTLE+2 cycles.
  - With start high in cycle 0, done is high in cycle num_vec*(SETTLE+2)+1.
  - For num_vec=0, done is high in cycle 1.
- res_we is high only in CAPTURE; exactly num_vec writes per run, to addresses 0..num_vec-1 in order.

Test Plan:
- Single vector, reference datapath, SETTLE=1, vec_data=15'h0000, exp=30'h035086E8, mask all-ones -> dut_in=0, res_we in cycle 3 with res_data=30'h035086E8, done in cycle 4, mismatch_cnt=0, fail_valid=0.
- num_vec=4, exp[2] with bit 0 flipped, mask all-ones -> 4 writes at addr 0..3, done in cycle 13, mismatch_cnt=1, first_fail=2. Repeat with cmp_mask bit0=0 -> mismatch_cnt=0.
- num_vec=16 (full depth), all exp wrong -> 16 writes, mismatch_cnt=16, first_fail=0, vec_addr ends at 15 with no wrap.
- num_vec=0 -> no res_we, done in cycle 1, busy never high. Then SETTLE=3, num_vec=1 -> dut_in stable for 3 cycles before CAPTURE, done in cycle 6.
- start pulsed mid-run -> ignored, run length unchanged.
- rst asserted in SETTLE of vector 1 -> outputs 0 immediately, no done pulse; a following start runs cleanly from addr 0.

Source files
------------

// File: rtl/vector_sequencer.sv
// vector_sequencer: steps a combinational datapath through a stored stimulus
// list, captures each result into a result memory and keeps mismatch stats.
module vector_sequencer #(
  parameter int unsigned DIN_W  = 15,
  parameter int unsigned DOUT_W = 30,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_num_vec,
  output logic [ADDR_W-1:0] o_vec_addr,
  input  logic [DIN_W-1:0]  i_vec_data,
  input  logic [DOUT_W-1:0] i_exp_data,
  input  logic [DOUT_W-1:0] i_cmp_mask,
  output logic [DIN_W-1:0]  o_dut_in,
  input  logic [DOUT_W-1:0] i_dut_out,
  output logic              o_res_we,
  output logic [ADDR_W-1:0] o_res_addr,
  output logic [DOUT_W-1:0] o_res_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_mismatch_cnt,
  output logic              o_fail_valid,
  output logic [ADDR_W-1:0] o_first_fail
);

  // Settle counter only ever holds SETTLE-1 down to 0.
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_vec_addr;
  logic [ADDR_W:0]     r_num_vec;
  logic [DOUT_W-1:0]   r_cmp_mask;
  logic [DIN_W-1:0]    r_dut_in;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W:0]     r_mismatch_cnt;
  logic                r_fail_valid;
  logic [ADDR_W-1:0]   r_first_fail;

  logic                w_capture;
  logic                w_last;
  logic                w_mismatch;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the capture-cycle compare and result-port drive.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_last     = ({1'b0, r_vec_addr} == (r_num_vec - (ADDR_W + 1)'(1)));
    w_mismatch = (((i_dut_out ^ i_exp_data) & r_cmp_mask) != '0);
    o_res_we   = 1'b0;
    o_res_addr = '0;
    o_res_data = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = (i_num_vec != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_capture  = 1'b1;
        o_res_we   = 1'b1;
        o_res_addr = r_vec_addr;
        o_res_data = i_dut_out;
        w_next     = w_last ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Run registers: address walk, settle timer, stimulus drive and statistics.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt          <= '0;
      r_vec_addr     <= '0;
      r_num_vec      <= '0;
      r_cmp_mask     <= '0;
      r_dut_in       <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_mismatch_cnt <= '0;
      r_fail_valid   <= 1'b0;
      r_first_fail   <= '0;
    end else begin
      r_busy <= (w_next == S_LOAD) || (w_next == S_SETTLE) || (w_next == S_CAPTURE);
      r_done <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_vec      <= i_num_vec;
            r_cmp_mask     <= i_cmp_mask;
            r_mismatch_cnt <= '0;
            r_fail_valid   <= 1'b0;
            r_first_fail   <= '0;
            r_vec_addr     <= '0;
          end
        end
        S_LOAD: begin
          r_dut_in <= i_vec_data;
          r_cnt    <= CNT_W'(SETTLE - 1);
        end
        S_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          if (w_mismatch) begin
            if (r_mismatch_cnt != '1) begin
              r_mismatch_cnt <= r_mismatch_cnt + (ADDR_W + 1)'(1);
            end
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_first_fail <= r_vec_addr;
            end
          end
          if (!w_last) begin
            r_vec_addr <= r_vec_addr + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_vec_addr     = r_vec_addr;
  assign o_dut_in       = r_dut_in;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_mismatch_cnt = r_mismatch_cnt;
  assign o_fail_valid   = r_fail_valid;
  assign o_first_fail   = r_first_fail;

endmodule
